usb_packet_scheduler: RTL and testbench



---
 rtl/usb_pkg.sv | 34 +++
 rtl/usb_req_arbiter.sv | 49 ++++
 rtl/usb_packet_scheduler.sv | 101 ++++++++++
 tb/tb_usb_packet_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared types and constants for the FT232H packet scheduler.
// Select indices address the byte selector; headers frame each packet type.
package usb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        TERM    = 2'd3
    } state_t;

    typedef enum logic {
        GNT_SAMPLE   = 1'b0,
        GNT_SETTINGS = 1'b1
    } grant_t;

    localparam logic [3:0] SEL_CH1_TH = 4'd0;
    localparam logic [3:0] SEL_CH1_H  = 4'd1;
    localparam logic [3:0] SEL_CH1_T  = 4'd2;
    localparam logic [3:0] SEL_CH1_O  = 4'd3;
    localparam logic [3:0] SEL_CH2_TH = 4'd4;
    localparam logic [3:0] SEL_CH2_H  = 4'd5;
    localparam logic [3:0] SEL_CH2_T  = 4'd6;
    localparam logic [3:0] SEL_CH2_O  = 4'd7;
    localparam logic [3:0] SEL_VSCALE = 4'd8;
    localparam logic [3:0] SEL_TSCALE = 4'd9;
    localparam logic [3:0] SEL_TRIG   = 4'd10;
    localparam logic [3:0] SEL_SWITCH = 4'd11;

    localparam logic [7:0] HDR_SAMPLE_BYTE   = 8'h53;
    localparam logic [7:0] HDR_SETTINGS_BYTE = 8'h43;
    localparam logic [7:0] TERM_BYTE_VAL     = 8'h0A;

endpackage

// File: rtl/usb_req_arbiter.sv
// Latches sample/settings requests, grants them round-robin while the
// scheduler is idle, and counts sample requests lost to overwrite.
module usb_req_arbiter
    import usb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_sample_req,
    input  logic       i_settings_req,
    input  logic       i_idle,
    output logic       o_grant_s,
    output logic       o_grant_c,
    output logic [7:0] o_dropped
);

    logic   r_pend_s;
    logic   r_pend_c;
    grant_t r_last_grant;
    logic [7:0] r_dropped;
    logic   w_pick_s;

    // When both are pending, the type not served last time wins.
    always_comb begin
        w_pick_s  = r_pend_s && (!r_pend_c || r_last_grant == GNT_SETTINGS);
        o_grant_s = i_idle && w_pick_s;
        o_grant_c = i_idle && r_pend_c && !w_pick_s;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend_s     <= 1'b0;
            r_pend_c     <= 1'b0;
            r_last_grant <= GNT_SETTINGS;
            r_dropped    <= 8'h00;
        end else begin
            r_pend_s <= (r_pend_s && !o_grant_s) || i_sample_req;
            r_pend_c <= (r_pend_c && !o_grant_c) || i_settings_req;
            if (o_grant_s)
                r_last_grant <= GNT_SAMPLE;
            else if (o_grant_c)
                r_last_grant <= GNT_SETTINGS;
            if (i_sample_req && r_pend_s && !o_grant_s && r_dropped != 8'hFF)
                r_dropped <= r_dropped + 8'd1;
        end
    end

    assign o_dropped = r_dropped;

endmodule

// File: rtl/usb_packet_scheduler.sv
// Frames sample and settings packets onto the FT232H write stream,
// stepping the selector index and honouring txe flow control.
module usb_packet_scheduler
    import usb_pkg::*;
#(
    parameter int         SAMPLE_BYTES   = 8,
    parameter int         SETTINGS_BYTES = 4,
    parameter logic [7:0] HDR_SAMPLE     = HDR_SAMPLE_BYTE,
    parameter logic [7:0] HDR_SETTINGS   = HDR_SETTINGS_BYTE,
    parameter logic [7:0] TERM_BYTE      = TERM_BYTE_VAL
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       sample_req,
    input  logic       settings_req,
    input  logic       txe,
    input  logic [7:0] byte_in,
    output logic [3:0] select,
    output logic [7:0] data_out,
    output logic       wr,
    output logic       sample_ack,
    output logic       settings_ack,
    output logic       busy,
    output logic [7:0] dropped
);

    localparam logic [3:0] LAST_SAMPLE   = 4'(SAMPLE_BYTES - 1);
    localparam logic [3:0] LAST_SETTINGS = 4'(32'(SEL_VSCALE) + SETTINGS_BYTES - 1);

    state_t     r_state;
    logic [3:0] r_select;
    logic       r_is_settings;
    logic       w_grant_s;
    logic       w_grant_c;
    logic       w_xfer;
    logic       w_last;

    usb_req_arbiter u_arb (
        .i_clk          (clk_in),
        .i_reset        (reset),
        .i_sample_req   (sample_req),
        .i_settings_req (settings_req),
        .i_idle         (r_state == IDLE),
        .o_grant_s      (w_grant_s),
        .o_grant_c      (w_grant_c),
        .o_dropped      (dropped)
    );

    assign w_xfer = (r_state != IDLE) && !txe;
    assign w_last = r_is_settings ? (r_select == LAST_SETTINGS) : (r_select == LAST_SAMPLE);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state       <= IDLE;
            r_select      <= SEL_CH1_TH;
            r_is_settings <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_s) begin
                        r_state       <= HEADER;
                        r_select      <= SEL_CH1_TH;
                        r_is_settings <= 1'b0;
                    end else if (w_grant_c) begin
                        r_state       <= HEADER;
                        r_select      <= SEL_VSCALE;
                        r_is_settings <= 1'b1;
                    end
                end
                HEADER:  if (w_xfer) r_state <= PAYLOAD;
                // select parks on the last payload index while the terminator goes out
                PAYLOAD: if (w_xfer) begin
                    if (w_last) r_state  <= TERM;
                    else        r_select <= r_select + 4'd1;
                end
                TERM: if (w_xfer) begin
                    r_state  <= IDLE;
                    r_select <= SEL_CH1_TH;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        data_out = 8'h00;
        case (r_state)
            HEADER:  data_out = r_is_settings ? HDR_SETTINGS : HDR_SAMPLE;
            PAYLOAD: data_out = byte_in;
            TERM:    data_out = TERM_BYTE;
            default: data_out = 8'h00;
        endcase
    end

    assign wr           = ~w_xfer;
    assign select       = r_select;
    assign sample_ack   = w_grant_s;
    assign settings_ack = w_grant_c;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_usb_packet_scheduler.sv
// Directed bench for usb_packet_scheduler: selector model returns 8'h30+select,
// a monitor logs every written byte with its cycle number.
module tb_usb_packet_scheduler;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       sample_req = 1'b0;
    logic       settings_req = 1'b0;
    logic       txe = 1'b0;
    logic [7:0] byte_in;
    logic [3:0] select;
    logic [7:0] data_out;
    logic       wr;
    logic       sample_ack;
    logic       settings_ack;
    logic       busy;
    logic [7:0] dropped;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [7:0] q[$];
    int         qc[$];
    logic [7:0] exp_q[$];

    usb_packet_scheduler dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .sample_req   (sample_req),
        .settings_req (settings_req),
        .txe          (txe),
        .byte_in      (byte_in),
        .select       (select),
        .data_out     (data_out),
        .wr           (wr),
        .sample_ack   (sample_ack),
        .settings_ack (settings_ack),
        .busy         (busy),
        .dropped      (dropped)
    );

    always #5 clk_in = ~clk_in;

    assign byte_in = 8'h30 + {4'h0, select};

    always @(posedge clk_in) begin
        cyc++;
        if (wr === 1'b0) begin
            q.push_back(data_out);
            qc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; sample_req = 1'b0; settings_req = 1'b0; txe = 1'b0;
        tick(); tick();
        reset = 1'b0;
        q.delete(); qc.delete(); exp_q.delete();
    endtask

    task automatic push_sample();
        exp_q.push_back(8'h53);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h30 + 8'(i));
        exp_q.push_back(8'h0A);
    endtask

    task automatic push_settings();
        exp_q.push_back(8'h43);
        for (int i = 8; i < 12; i++) exp_q.push_back(8'h30 + 8'(i));
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_idle(input string tag, input int lim);
        for (int i = 0; i < lim && busy !== 1'b0; i++) tick();
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic wait_q(input string tag, input int n, input int lim);
        for (int i = 0; i < lim && q.size() < n; i++) tick();
        chk({tag, "_count_reached"}, q.size(), n);
    endtask

    task automatic chk_bytes(input string tag);
        chk({tag, "_len"}, q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), (i < q.size()) ? q[i] : 8'hXX, exp_q[i]);
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_wr", wr, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_select", select, 4'd0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_dropped", dropped, 8'h00);
        chk("rst_acks", {sample_ack, settings_ack}, 2'b00);

        // single sample packet, back to back
        sample_req = 1'b1; tick(); sample_req = 1'b0;
        chk("t1_ack_s", sample_ack, 1'b1);
        chk("t1_ack_c", settings_ack, 1'b0);
        chk("t1_wr_grant", wr, 1'b1);
        tick();
        chk("t1_wr_hdr", wr, 1'b0);
        chk("t1_hdr", data_out, 8'h53);
        chk("t1_ack_gone", sample_ack, 1'b0);
        wait_idle("t1", 30);
        push_sample();
        chk_bytes("t1");
        chk("t1_span", (qc.size() == 10) ? qc[9] - qc[0] : -1, 9);

        // simultaneous requests after reset: sample first, then settings
        do_reset();
        sample_req = 1'b1; settings_req = 1'b1; tick();
        sample_req = 1'b0; settings_req = 1'b0;
        chk("t2_ack_s", sample_ack, 1'b1);
        chk("t2_ack_c", settings_ack, 1'b0);
        wait_q("t2", 16, 60);
        push_sample(); push_settings();
        chk_bytes("t2");
        chk("t2_gap", (qc.size() >= 11) ? qc[10] - qc[9] : -1, 2);
        wait_idle("t2", 10);

        // txe stall at payload select 3
        do_reset();
        sample_req = 1'b1; tick(); sample_req = 1'b0;
        for (int i = 0; i < 20 && !(busy && select == 4'd3); i++) tick();
        chk("t3_reach", select, 4'd3);
        txe = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t3_wr%0d", i), wr, 1'b1);
            chk($sformatf("t3_sel%0d", i), select, 4'd3);
            chk($sformatf("t3_dat%0d", i), data_out, 8'h33);
        end
        txe = 1'b0;
        wait_idle("t3", 30);
        push_sample();
        chk_bytes("t3");

        // three sample requests during a settings packet
        do_reset();
        settings_req = 1'b1; tick(); settings_req = 1'b0;
        tick();
        sample_req = 1'b1; tick(); sample_req = 1'b0; tick();
        sample_req = 1'b1; tick(); sample_req = 1'b0; tick();
        sample_req = 1'b1; tick(); sample_req = 1'b0;
        chk("t4_dropped", dropped, 8'd2);
        chk("t4_busy", busy, 1'b1);
        wait_q("t4", 16, 60);
        push_settings(); push_sample();
        chk_bytes("t4");
        wait_idle("t4", 10);

        // same-cycle re-request kept, later one dropped, then reset mid-payload
        do_reset();
        sample_req = 1'b1; tick();
        chk("t5_ack", sample_ack, 1'b1);
        tick(); sample_req = 1'b0;
        chk("t5_keep", dropped, 8'd0);
        tick(); sample_req = 1'b1; tick(); sample_req = 1'b0;
        chk("t5_drop", dropped, 8'd1);
        for (int i = 0; i < 20 && !(busy && select == 4'd5); i++) tick();
        chk("t5_reach", select, 4'd5);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t5_wr", wr, 1'b1);
        chk("t5_busy", busy, 1'b0);
        chk("t5_select", select, 4'd0);
        chk("t5_dropped", dropped, 8'd0);
        q.delete(); qc.delete();
        for (int i = 0; i < 15; i++) tick();
        chk("t5_no_writes", q.size(), 0);
        chk("t5_still_idle", busy, 1'b0);

        // overrun saturation while stalled in HEADER
        do_reset();
        txe = 1'b1;
        sample_req = 1'b1; tick(); sample_req = 1'b0; tick();
        chk("t6_stall_hdr", data_out, 8'h53);
        sample_req = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("t6_drop9", dropped, 8'd9);
        for (int i = 0; i < 291; i++) tick();
        sample_req = 1'b0;
        chk("t6_sat", dropped, 8'hFF);
        chk("t6_wr", wr, 1'b1);

        // txe toggling every cycle
        do_reset();
        sample_req = 1'b1; tick(); sample_req = 1'b0;
        for (int i = 0; i < 60 && !(q.size() >= 10 && !busy); i++) begin
            tick();
            txe = ~txe;
        end
        txe = 1'b0;
        push_sample();
        chk_bytes("t7");
        chk("t7_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
